// File: rtl/max_finder_pkg.sv
// Shared types and default widths for the per-line peak detector.
package max_finder_pkg;

   localparam int unsigned DATA_W = 8;
   localparam int unsigned POS_W  = 9;
   localparam int unsigned CNT_W  = 10;

   typedef enum logic {
      IDLE  = 1'b0,
      ACCUM = 1'b1
   } state_t;

endpackage

// File: rtl/sat_counter.sv
// Up-counter with synchronous clear that sticks at all-ones.
module sat_counter #(
   parameter int unsigned CNT_W = 10
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clear,
   input  logic             inc,
   output logic [CNT_W-1:0] count
);

   // Clear has priority; increments stop once the counter is full.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count <= '0;
      end else if (clear) begin
         count <= '0;
      end else if (inc && (count != '1)) begin
         count <= count + CNT_W'(1);
      end
   end

endmodule

// File: rtl/max_finder_thr.sv
// Per-line peak detector: running max/position, threshold hit span and count,
// results published one cycle after line_end with a one-cycle strobe.
module max_finder_thr #(
   parameter int unsigned DATA_W   = max_finder_pkg::DATA_W,
   parameter int unsigned POS_W    = max_finder_pkg::POS_W,
   parameter int unsigned CNT_W    = max_finder_pkg::CNT_W,
   parameter bit          TIE_LAST = 1'b0
) (
   input  logic              clk_in,
   input  logic              rst_n,
   input  logic              start,
   input  logic              data_valid,
   input  logic [DATA_W-1:0] data_in,
   input  logic [POS_W-1:0]  data_pos,
   input  logic              line_end,
   input  logic [DATA_W-1:0] threshold,
   output logic [DATA_W-1:0] max_value,
   output logic [POS_W-1:0]  max_pos,
   output logic [POS_W-1:0]  first_pos,
   output logic [POS_W-1:0]  last_pos,
   output logic [CNT_W-1:0]  above_cnt,
   output logic              peak_found,
   output logic              result_valid,
   output logic              busy
);

   import max_finder_pkg::*;

   state_t              state;
   logic [DATA_W-1:0]   thr;
   logic [DATA_W-1:0]   run_max;
   logic [POS_W-1:0]    run_pos;
   logic [POS_W-1:0]    run_first;
   logic [POS_W-1:0]    run_last;
   logic                run_seen;
   logic [CNT_W-1:0]    run_cnt;
   logic                done_pend;

   logic                accept_c;
   logic                hit_c;
   logic                take_c;

   // Sample qualification: start discards the coincident sample.
   always_comb begin
      accept_c = 1'b0;
      hit_c    = 1'b0;
      take_c   = 1'b0;
      accept_c = (state == ACCUM) && !start && data_valid;
      hit_c    = accept_c && (data_in >= thr);
      take_c   = accept_c && (!run_seen || (data_in > run_max) ||
                              (TIE_LAST && (data_in == run_max)));
   end

   sat_counter #(
      .CNT_W (CNT_W)
   ) u_sat_counter (
      .clk   (clk_in),
      .rst_n (rst_n),
      .clear (start),
      .inc   (hit_c),
      .count (run_cnt)
   );

   // Line FSM, running accumulators and published result registers.
   always_ff @(posedge clk_in or negedge rst_n) begin
      if (!rst_n) begin
         state        <= IDLE;
         thr          <= '0;
         run_max      <= '0;
         run_pos      <= '0;
         run_first    <= '0;
         run_last     <= '0;
         run_seen     <= 1'b0;
         done_pend    <= 1'b0;
         max_value    <= '0;
         max_pos      <= '0;
         first_pos    <= '0;
         last_pos     <= '0;
         above_cnt    <= '0;
         peak_found   <= 1'b0;
         result_valid <= 1'b0;
         busy         <= 1'b0;
      end else begin
         result_valid <= 1'b0;
         done_pend    <= 1'b0;

         // Publish the line closed on the previous edge (uses pre-clear values).
         if (done_pend) begin
            max_value    <= run_max;
            max_pos      <= run_pos;
            first_pos    <= run_first;
            last_pos     <= run_last;
            above_cnt    <= run_cnt;
            peak_found   <= (run_cnt != '0);
            result_valid <= 1'b1;
         end

         if (start) begin
            state     <= ACCUM;
            busy      <= 1'b1;
            thr       <= threshold;
            run_max   <= '0;
            run_pos   <= '0;
            run_first <= '0;
            run_last  <= '0;
            run_seen  <= 1'b0;
         end else if (state == ACCUM) begin
            if (take_c) begin
               run_max  <= data_in;
               run_pos  <= data_pos;
               run_seen <= 1'b1;
            end
            if (hit_c) begin
               if (run_cnt == '0) begin
                  run_first <= data_pos;
               end
               run_last <= data_pos;
            end
            if (line_end) begin
               state     <= IDLE;
               busy      <= 1'b0;
               done_pend <= 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_max_finder_thr.sv
// Bench for max_finder_thr: three parameter variants share one stimulus stream
// and are compared against a line-level reference model.
module tb_max_finder_thr;

   logic       clk_in = 1'b0;
   logic       rst_n;
   logic       start;
   logic       data_valid;
   logic [7:0] data_in;
   logic [8:0] data_pos;
   logic       line_end;
   logic [7:0] threshold;

   logic [7:0] mv [3];
   logic [8:0] mp [3];
   logic [8:0] fp [3];
   logic [8:0] lp [3];
   logic       pf [3];
   logic       rv [3];
   logic       bz [3];
   logic [9:0] ac0, ac1;
   logic [1:0] ac2;

   int checks = 0;
   int errors = 0;

   // Reference model state
   int  qd[$];
   int  qp[$];
   int  thr_l;
   bit  active;
   bit  pend;
   int  exp_mv[3], exp_mp[3], exp_fp[3], exp_lp[3], exp_ac[3], exp_pf[3];
   int  pnd_mv[3], pnd_mp[3], pnd_fp[3], pnd_lp[3], pnd_ac[3], pnd_pf[3];
   bit  exp_rv;

   always #5 clk_in = ~clk_in;

   max_finder_thr #(.DATA_W(8), .POS_W(9), .CNT_W(10), .TIE_LAST(1'b0)) dut0 (
      .clk_in(clk_in), .rst_n(rst_n), .start(start), .data_valid(data_valid),
      .data_in(data_in), .data_pos(data_pos), .line_end(line_end), .threshold(threshold),
      .max_value(mv[0]), .max_pos(mp[0]), .first_pos(fp[0]), .last_pos(lp[0]),
      .above_cnt(ac0), .peak_found(pf[0]), .result_valid(rv[0]), .busy(bz[0]));

   max_finder_thr #(.DATA_W(8), .POS_W(9), .CNT_W(10), .TIE_LAST(1'b1)) dut1 (
      .clk_in(clk_in), .rst_n(rst_n), .start(start), .data_valid(data_valid),
      .data_in(data_in), .data_pos(data_pos), .line_end(line_end), .threshold(threshold),
      .max_value(mv[1]), .max_pos(mp[1]), .first_pos(fp[1]), .last_pos(lp[1]),
      .above_cnt(ac1), .peak_found(pf[1]), .result_valid(rv[1]), .busy(bz[1]));

   max_finder_thr #(.DATA_W(8), .POS_W(9), .CNT_W(2), .TIE_LAST(1'b0)) dut2 (
      .clk_in(clk_in), .rst_n(rst_n), .start(start), .data_valid(data_valid),
      .data_in(data_in), .data_pos(data_pos), .line_end(line_end), .threshold(threshold),
      .max_value(mv[2]), .max_pos(mp[2]), .first_pos(fp[2]), .last_pos(lp[2]),
      .above_cnt(ac2), .peak_found(pf[2]), .result_valid(rv[2]), .busy(bz[2]));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
      end
   endtask

   // Whole-line result from the collected samples, per variant
   task automatic compute(input int i);
      bit tie;
      int cw, m, pos, hits, first, last, sat;
      bit got;
      tie = (i == 1);
      cw  = (i == 2) ? 2 : 10;
      m = 0; pos = 0; hits = 0; first = 0; last = 0; got = 0;
      foreach (qd[k]) if (qd[k] > m) m = qd[k];
      foreach (qd[k]) begin
         if (qd[k] == m) begin
            if (tie) pos = qp[k];
            else if (!got) begin pos = qp[k]; got = 1; end
         end
         if (qd[k] >= thr_l) begin
            if (hits == 0) first = qp[k];
            last = qp[k];
            hits++;
         end
      end
      sat = (1 << cw) - 1;
      pnd_mv[i] = m;
      pnd_mp[i] = pos;
      pnd_fp[i] = first;
      pnd_lp[i] = last;
      pnd_ac[i] = (hits > sat) ? sat : hits;
      pnd_pf[i] = (hits > 0) ? 1 : 0;
   endtask

   task automatic check_all();
      logic [9:0] acv;
      for (int i = 0; i < 3; i++) begin
         acv = (i == 0) ? ac0 : (i == 1) ? ac1 : 10'(ac2);
         chk($sformatf("d%0d.result_valid", i), 32'(rv[i]), 32'(exp_rv));
         chk($sformatf("d%0d.busy", i),         32'(bz[i]), 32'(active));
         chk($sformatf("d%0d.max_value", i),    32'(mv[i]), exp_mv[i]);
         chk($sformatf("d%0d.max_pos", i),      32'(mp[i]), exp_mp[i]);
         chk($sformatf("d%0d.first_pos", i),    32'(fp[i]), exp_fp[i]);
         chk($sformatf("d%0d.last_pos", i),     32'(lp[i]), exp_lp[i]);
         chk($sformatf("d%0d.above_cnt", i),    32'(acv),   exp_ac[i]);
         chk($sformatf("d%0d.peak_found", i),   32'(pf[i]), exp_pf[i]);
      end
   endtask

   task automatic model_reset();
      qd.delete(); qp.delete();
      thr_l = 0; active = 0; pend = 0; exp_rv = 0;
      for (int i = 0; i < 3; i++) begin
         exp_mv[i] = 0; exp_mp[i] = 0; exp_fp[i] = 0;
         exp_lp[i] = 0; exp_ac[i] = 0; exp_pf[i] = 0;
      end
   endtask

   // One clock: drive inputs, clock, advance model, check all variants
   task automatic step(input bit st, input bit dv, input bit le,
                       input int d, input int p, input int th);
      start      = st;
      data_valid = dv;
      line_end   = le;
      data_in    = 8'(d);
      data_pos   = 9'(p);
      threshold  = 8'(th);
      @(posedge clk_in);
      #1;
      exp_rv = pend;
      if (pend) begin
         for (int i = 0; i < 3; i++) begin
            exp_mv[i] = pnd_mv[i]; exp_mp[i] = pnd_mp[i]; exp_fp[i] = pnd_fp[i];
            exp_lp[i] = pnd_lp[i]; exp_ac[i] = pnd_ac[i]; exp_pf[i] = pnd_pf[i];
         end
         pend = 0;
      end
      if (st) begin
         active = 1;
         qd.delete(); qp.delete();
         thr_l = th;
      end else if (active) begin
         if (dv) begin qd.push_back(d); qp.push_back(p); end
         if (le) begin
            for (int i = 0; i < 3; i++) compute(i);
            pend   = 1;
            active = 0;
         end
      end
      check_all();
   endtask

   initial begin
      int n, vals[8];
      vals = '{0, 30, 60, 95, 120, 120, 200, 255};
      rst_n = 0; start = 0; data_valid = 0; line_end = 0;
      data_in = 0; data_pos = 0; threshold = 0;
      model_reset();
      #12;
      check_all();
      @(negedge clk_in);
      rst_n = 1;

      // Basic line with coincident last sample
      step(1, 0, 0, 0,   0,   95);
      step(0, 1, 0, 100, 123, 0);
      step(0, 1, 0, 110, 130, 250);
      step(0, 1, 1, 90,  140, 0);
      step(0, 0, 0, 0,   0,   0);
      step(0, 0, 0, 0,   0,   0);

      // Tie-break, no threshold hits
      step(1, 0, 0, 0,  0,  200);
      step(0, 1, 0, 50, 10, 0);
      step(0, 1, 0, 80, 20, 0);
      step(0, 1, 1, 80, 30, 0);
      step(0, 0, 0, 0,  0,  0);
      step(0, 0, 0, 0,  0,  0);

      // Empty line
      step(1, 0, 0, 0, 0, 10);
      step(0, 0, 1, 0, 0, 0);
      step(0, 0, 0, 0, 0, 0);

      // Line A, then line B aborted by start+line_end
      step(1, 0, 0, 0,   0,   95);
      step(0, 1, 0, 100, 123, 0);
      step(0, 1, 0, 110, 130, 0);
      step(0, 1, 1, 90,  140, 0);
      step(0, 0, 0, 0,   0,   0);
      step(1, 0, 0, 0,   0,   0);
      step(0, 1, 0, 250, 7,   0);
      step(1, 1, 1, 255, 8,   0);
      step(0, 0, 0, 0,   0,   0);
      step(0, 0, 0, 0,   0,   0);

      // Saturation with threshold 0
      step(1, 0, 0, 0, 0, 0);
      for (int k = 1; k <= 5; k++) step(0, 1, (k == 5), k * 3, k, 0);
      step(0, 0, 0, 0, 0, 0);

      // Ignored activity in IDLE
      step(0, 1, 1, 255, 1, 0);
      step(0, 1, 0, 255, 2, 0);

      // Randomized lines
      for (int l = 0; l < 40; l++) begin
         step(1, 0, 0, 0, 0, vals[$urandom_range(0, 7)]);
         n = $urandom_range(0, 10);
         for (int k = 0; k < n; k++)
            step(0, ($urandom_range(0, 3) != 0), 0, vals[$urandom_range(0, 7)],
                 $urandom_range(0, 511), $urandom_range(0, 255));
         if ($urandom_range(0, 7) == 0)
            step(1, $urandom_range(0, 1), 1, vals[$urandom_range(0, 7)], 3, 0);
         else
            step(0, $urandom_range(0, 1), 1, vals[$urandom_range(0, 7)],
                 $urandom_range(0, 511), 0);
         n = $urandom_range(0, 2);
         for (int k = 0; k < n; k++)
            step(0, $urandom_range(0, 1), $urandom_range(0, 1), vals[$urandom_range(0, 7)],
                 $urandom_range(0, 511), 0);
      end
      step(0, 0, 0, 0, 0, 0);

      // Make sure results are non-zero, then reset mid-line
      step(1, 0, 0, 0,   0,   95);
      step(0, 1, 1, 100, 123, 0);
      step(0, 0, 0, 0,   0,   0);
      step(1, 0, 0, 0,   0,   50);
      step(0, 1, 0, 60,  1,   0);
      step(0, 1, 0, 70,  2,   0);
      step(0, 1, 0, 80,  3,   0);
      #2;
      rst_n = 0;
      #1;
      model_reset();
      check_all();
      @(posedge clk_in);
      #2;
      rst_n = 1;
      step(0, 1, 1, 90, 4, 0);
      step(0, 0, 0, 0,  0, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
